// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one full-adder cell, LSB first, one bit per clock.
// Start/done handshake; result and flags held from done until the next op completes.
module serial_add_sub #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  opa_q, opa_d, opb_q, opb_d, res_q, res_d, res_next;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              carry_q, carry_d;
  logic              c_out_q, c_out_d, ovf_q, ovf_d, zero_q, zero_d;
  logic              accept, last, fa_s, fa_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  assign last = (cnt_q == CntW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (last) state_d = StDone;
      StDone:  state_d = start ? StRun : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy = (state_q == StRun);
    done = (state_q == StDone);
  end

  // Single full-adder cell fed from the operand shift registers.
  assign fa_s     = opa_q[0] ^ opb_q[0] ^ carry_q;
  assign fa_c     = (opa_q[0] & opb_q[0]) | (carry_q & (opa_q[0] ^ opb_q[0]));
  assign res_next = {fa_s, res_q[WIDTH-1:1]};
  assign accept   = start && (state_q != StRun);

  always_comb begin
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    if (accept) begin
      opa_d   = a;
      opb_d   = sub ? ~b : b;
      carry_d = sub;
      cnt_d   = '0;
      res_d   = '0;
    end else if (state_q == StRun) begin
      opa_d   = {1'b0, opa_q[WIDTH-1:1]};
      opb_d   = {1'b0, opb_q[WIDTH-1:1]};
      res_d   = res_next;
      carry_d = fa_c;
      cnt_d   = cnt_q + CntW'(1);
      if (last) begin
        sum_d   = res_next;
        c_out_d = fa_c;
        ovf_d   = carry_q ^ fa_c;
        zero_d  = (res_next == '0);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign sum      = sum_q;
  assign c_out    = c_out_q;
  assign overflow = ovf_q;
  assign zero     = zero_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Scoreboard bench for serial_add_sub (WIDTH=8): driver pushes expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_serial_add_sub;

  logic       clk = 1'b0;
  logic       rst, start, sub;
  logic [7:0] a, b;
  logic       busy, done, c_out, overflow, zero;
  logic [7:0] sum;

  serial_add_sub #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .sum(sum), .c_out(c_out),
    .overflow(overflow), .zero(zero)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] s;
    logic       c;
    logic       v;
    logic       z;
  } exp_t;

  exp_t       sb_q[$];
  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] prev_sum = 8'h00;
  logic       done_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: compares each done pulse against the oldest pending expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      chk("done_pulse_width", {31'd0, done_prev}, 32'd0);
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sum", {24'd0, sum}, {24'd0, e.s});
        chk("c_out", {31'd0, c_out}, {31'd0, e.c});
        chk("overflow", {31'd0, overflow}, {31'd0, e.v});
        chk("zero", {31'd0, zero}, {31'd0, e.z});
      end
    end
    done_prev = rst ? 1'b0 : done;
  end

  // Caller is at a negedge; returns at the negedge where done is seen.
  task automatic run_op(input logic [7:0] va, input logic [7:0] vb, input logic vs,
                        input logic [7:0] es, input logic ec, input logic ev,
                        input logic ez, input bit disturb);
    int cyc;
    bit got;
    sb_q.push_back('{s: es, c: ec, v: ev, z: ez});
    a = va; b = vb; sub = vs; start = 1'b1;
    cyc = 0; got = 0;
    while (!got && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) start = 1'b0;
      if (disturb && cyc == 3) begin
        start = 1'b1; a = 8'h11; b = 8'h77; sub = 1'b0;
      end
      if (disturb && cyc == 4) start = 1'b0;
      if (cyc == 4) begin
        chk("sum_held_during_run", {24'd0, sum}, {24'd0, prev_sum});
        chk("busy_in_run", {31'd0, busy}, 32'd1);
      end
      if (done) got = 1;
    end
    chk("latency", cyc, 32'd9);
    prev_sum = es;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] t6_a [4];
    logic [7:0] t6_b [4];
    logic       t6_s [4];
    exp_t       t6_e [4];
    int         cyc;
    bit         got;

    rst = 1'b1; start = 1'b0; sub = 1'b0; a = 8'h00; b = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {20'd0, busy, done, sum, c_out, overflow, zero},
        32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1..4: directed vectors
    run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 0);
    @(negedge clk);
    run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 0);
    run_op(8'h05, 8'h05, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 0);
    repeat (3) @(negedge clk);
    chk("sum_held_idle", {24'd0, sum, 7'd0, zero}, {24'd0, 8'h00, 7'd0, 1'b1});
    run_op(8'h03, 8'h05, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0, 0);
    run_op(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0, 1);
    @(negedge clk);

    // 5: reset on the 4th RUN cycle aborts the op
    a = 8'h10; b = 8'h20; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async_reset_outputs", {20'd0, busy, done, sum, c_out, overflow, zero}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    prev_sum = 8'h00;
    repeat (12) @(negedge clk);
    chk("idle_after_abort", {30'd0, busy, done}, 32'd0);
    run_op(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0, 0);

    // 6: start held high, new operands at each done
    t6_a = '{8'h12, 8'h60, 8'hF0, 8'h00};
    t6_b = '{8'h34, 8'h50, 8'h10, 8'h01};
    t6_s = '{1'b0, 1'b0, 1'b1, 1'b1};
    t6_e = '{'{s: 8'h46, c: 1'b0, v: 1'b0, z: 1'b0},
             '{s: 8'hB0, c: 1'b0, v: 1'b1, z: 1'b0},
             '{s: 8'hE0, c: 1'b1, v: 1'b0, z: 1'b0},
             '{s: 8'hFF, c: 1'b0, v: 1'b0, z: 1'b0}};
    sb_q.push_back(t6_e[0]);
    a = t6_a[0]; b = t6_b[0]; sub = t6_s[0]; start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc = 0; got = 0;
      while (!got && cyc < 30) begin
        @(negedge clk);
        cyc++;
        if (cyc == 4) chk("b2b_sum_held", {24'd0, sum}, {24'd0, prev_sum});
        if (done) got = 1;
      end
      chk("b2b_latency", cyc, 32'd9);
      prev_sum = t6_e[i].s;
      if (i < 3) begin
        sb_q.push_back(t6_e[i+1]);
        a = t6_a[i+1]; b = t6_b[i+1]; sub = t6_s[i+1];
      end else begin
        start = 1'b0;
      end
    end
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb_q.size(), 32'd0);
    chk("final_idle", {30'd0, busy, done}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
